lfsr_stream_checker: RTL and testbench
======================================

// Module: lfsr_stream_checker
// PURPOSE
//  Receive-side checker for the 8-bit LFSR pattern stream that the pattern generator drives on uo_out.
//  Locks onto the incoming byte sequence, then predicts each following byte locally.
//  Counts mismatches and declares loss of lock after repeated misses.
//  Sits on the capture side of a board loopback, or beside the generator in the test harness.
// PARAMETERS
//  LOCK_COUNT  4      consecutive correct predictions in VERIFY needed to enter LOCKED (1..15)
//  LOSS_COUNT  3      consecutive mismatches in LOCKED that force return to HUNT (1..15)
//  ERR_W       16     width of the saturating error counter
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      asynchronous reset, active-high
//  clr        in   1      synchronous clear of err_count; state and lock are unaffected
//  data_in    in   8      sampled stream byte
//  valid_in   in   1      data_in is a new sample this cycle
//  locked     out  1      checker is in LOCKED
//  err_pulse  out  1      one-cycle pulse: a LOCKED sample mismatched
//  err_count  out  ERR_W  mismatches seen while LOCKED, saturates at all-ones
//  wrap_pulse out  1      one-cycle pulse: a LOCKED sample matched and equals 8'h01 (period marker)
//  state_o    out  2      current state: 0=HUNT, 1=VERIFY, 2=LOCKED
// BEHAVIOUR
//  - LFSR step: nxt(q) = {q[6:7-7], fb} = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
//    This is x^8+x^6+x^5+x^4+1, period 255; 8'h00 is never a legal sample.
//  - Internal expected register exp[7:0]; cons[3:0] counts matches in VERIFY and misses in LOCKED.
//  - Reset (async): state=HUNT, exp=0, cons=0, err_count=0.
//    locked=0, err_pulse=0, wrap_pulse=0, state_o=0.
//  - All outputs are registered and reflect a sample on the clock edge that consumes it (1-cycle latency).
//  - Cycles with valid_in=0 change nothing, and pulses drop to 0.
//  - HUNT, valid sample s:
//    s==0: stay in HUNT.
//    else: exp<=nxt(s), cons<=0, go to VERIFY.
//  - VERIFY, valid sample s:
//    s==exp: exp<=nxt(s), cons++. When cons+1==LOCK_COUNT: go to LOCKED, cons<=0.
//    s!=exp, s!=0: reseed, i.e. exp<=nxt(s), cons<=0, stay in VERIFY.
//    s==0: go to HUNT.
//  - LOCKED, valid sample s. The flywheel always advances: exp<=nxt(exp), whatever s is.
//    s==exp: cons<=0; wrap_pulse=1 if s==8'h01.
//    s!=exp: err_pulse=1, err_count++ (saturating), cons++.
//      When cons+1==LOSS_COUNT: go to HUNT, cons<=0. err_count is held; locked drops on that same edge.
//  - clr together with an error on the same edge: err_count<=0. clr wins and that error is not counted.
//  - locked is 1 only in LOCKED. state_o never takes the value 3; decode 3 as HUNT.
//  - Reset asserted mid-stream aborts at once, and no pulse is emitted.
//    After release the checker re-hunts from the next valid sample.
// TESTING
//  1 Reset, then feed the clean sequence seeded at 8'h01, one byte per cycle.
//    -> locked=1 after exactly 1+LOCK_COUNT samples (5), err_count=0.
//    -> wrap_pulse fires every 255 locked samples.
//  2 While locked, flip one byte (0x02->0x03), then resume the correct sequence.
//    -> a single err_pulse, err_count=1, locked stays 1.
//  3 While locked, corrupt 3 consecutive bytes.
//    -> err_count=3, locked falls on the 3rd error.
//    -> relocks 5 samples after the clean data resumes.
//  4 Feed 8'h00 repeatedly, then random non-LFSR bytes.
//    -> locked never rises; state stays HUNT/VERIFY; err_count=0.
//  5 Apply gaps with valid_in=0 between the clean samples.
//    -> lock time counts valid samples only, no errors.
//    -> assert clr and an error on the same cycle -> err_count=0.
//  6 Assert rst mid-LOCKED -> all outputs 0 immediately. After release, the clean stream relocks within 5 samples.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for an 8-bit LFSR byte stream (x^8+x^6+x^5+x^4+1).
// Hunts for a seed, verifies LOCK_COUNT predictions, then flywheels and counts mismatches.
module lfsr_stream_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    state_t           r_state;
    logic [7:0]       r_exp;
    logic [3:0]       r_cons;
    logic [ERR_W-1:0] r_err_count;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_wrap_pulse;

    state_t           w_state;
    logic [7:0]       w_exp;
    logic [3:0]       w_cons;
    logic [ERR_W-1:0] w_err_count;
    logic             w_err_pulse;
    logic             w_wrap_pulse;
    logic [3:0]       w_cons_inc;

    assign w_cons_inc = r_cons + 4'd1;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_exp        <= 8'h00;
            r_cons       <= 4'd0;
            r_err_count  <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_exp        <= w_exp;
            r_cons       <= w_cons;
            r_err_count  <= w_err_count;
            r_locked     <= (w_state == ST_LOCKED);
            r_err_pulse  <= w_err_pulse;
            r_wrap_pulse <= w_wrap_pulse;
        end
    end

    // Next-state, prediction and error accounting
    always_comb begin
        w_state      = r_state;
        w_exp        = r_exp;
        w_cons       = r_cons;
        w_err_count  = r_err_count;
        w_err_pulse  = 1'b0;
        w_wrap_pulse = 1'b0;

        if (valid_in) begin
            case (r_state)
                ST_HUNT: begin
                    if (data_in != 8'h00) begin
                        w_exp   = lfsr_nxt(data_in);
                        w_cons  = 4'd0;
                        w_state = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (data_in == 8'h00) begin
                        w_state = ST_HUNT;
                    end else if (data_in == r_exp) begin
                        w_exp = lfsr_nxt(data_in);
                        if (w_cons_inc == 4'(LOCK_COUNT)) begin
                            w_state = ST_LOCKED;
                            w_cons  = 4'd0;
                        end else begin
                            w_cons = w_cons_inc;
                        end
                    end else begin
                        w_exp  = lfsr_nxt(data_in);
                        w_cons = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel keeps running regardless of the received byte
                    w_exp = lfsr_nxt(r_exp);
                    if (data_in == r_exp) begin
                        w_cons       = 4'd0;
                        w_wrap_pulse = (data_in == 8'h01);
                    end else begin
                        w_err_pulse = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_count = r_err_count + ERR_W'(1);
                        end
                        if (w_cons_inc == 4'(LOSS_COUNT)) begin
                            w_state = ST_HUNT;
                            w_cons  = 4'd0;
                        end else begin
                            w_cons = w_cons_inc;
                        end
                    end
                end
                default: begin
                    w_state = ST_HUNT;
                end
            endcase
        end

        if (clr) begin
            w_err_count = '0;
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign wrap_pulse = r_wrap_pulse;
    assign state_o    = r_state;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: vector table, directed corner sequences and
// randomized traffic against a table-indexed model of the 255-byte LFSR period.
module tb_lfsr_stream_checker;

    localparam int unsigned LOCK  = 4;
    localparam int unsigned LOSS  = 3;
    localparam int unsigned ERR_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [7:0]       data_in;
    logic             valid_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             wrap_pulse;
    logic [1:0]       state_o;

    lfsr_stream_checker #(
        .LOCK_COUNT(LOCK),
        .LOSS_COUNT(LOSS),
        .ERR_W     (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .wrap_pulse(wrap_pulse),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Period table: tab[i] is the i-th byte of the sequence seeded at 8'h01
    logic [7:0] tab [255];
    int         pos [256];

    // Model: position in the period table rather than an expected-byte register
    int m_state;
    int m_idx;
    int m_run;
    int m_err;
    bit m_errp;
    bit m_wrap;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        v;
        logic        c;
        logic [7:0]  d;
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic        wp;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({state_o, locked, err_pulse, wrap_pulse, err_count});
    endfunction

    function automatic logic [31:0] model_vec();
        logic [1:0] st;
        logic [15:0] ec;
        st = 2'(m_state);
        ec = 16'(m_err);
        return 32'({st, (m_state == 2), m_errp, m_wrap, ec});
    endfunction

    function automatic logic [7:0] clean();
        return tab[m_idx];
    endfunction

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_run = 0; m_err = 0; m_errp = 0; m_wrap = 0;
    endtask

    task automatic model_update(input bit v, input bit c, input logic [7:0] d);
        bit hit;
        m_errp = 0;
        m_wrap = 0;
        if (v) begin
            case (m_state)
                0: if (d != 8'h00) begin
                    m_idx = (pos[d] + 1) % 255; m_run = 0; m_state = 1;
                end
                1: if (d == 8'h00) begin
                    m_state = 0;
                end else if (d == tab[m_idx]) begin
                    m_idx = (m_idx + 1) % 255;
                    m_run++;
                    if (m_run == LOCK) begin m_state = 2; m_run = 0; end
                end else begin
                    m_idx = (pos[d] + 1) % 255; m_run = 0;
                end
                default: begin
                    hit   = (d == tab[m_idx]);
                    m_idx = (m_idx + 1) % 255;
                    if (hit) begin
                        m_run = 0;
                        m_wrap = (d == 8'h01);
                    end else begin
                        m_errp = 1;
                        if (m_err < (1 << ERR_W) - 1) m_err++;
                        m_run++;
                        if (m_run == LOSS) begin m_state = 0; m_run = 0; end
                    end
                end
            endcase
        end
        if (c) m_err = 0;
    endtask

    task automatic drive(input bit v, input bit c, input logic [7:0] d);
        @(negedge clk);
        valid_in = v; clr = c; data_in = d;
        @(posedge clk);
        #1;
        model_update(v, c, d);
    endtask

    task automatic step(input string name, input bit v, input bit c, input logic [7:0] d);
        drive(v, c, d);
        check(name, dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 0; clr = 0; data_in = 8'h00;
        rst = 1;
        @(posedge clk); #1;
        check("reset_outputs", dut_vec(), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    function automatic logic [7:0] corrupt(input logic [7:0] d);
        return (d == 8'hFF) ? 8'h7E : d + 8'd1;
    endfunction

    initial begin
        logic [7:0] q, d;
        int cnt, wraps_fed, wraps_seen, lk_seen, e0;
        bit done;

        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            tab[i] = q;
            pos[q] = i;
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        pos[0] = 0;

        tbl[0]  = '{1'b1, 1'b0, 8'h01, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h02, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h04, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 8'h08, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h11, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h23, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'h47, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, 1'b0, 8'h1C, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[11] = '{1'b1, 1'b0, 8'h38, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0};

        rst = 1; clr = 0; valid_in = 0; data_in = 8'h00;
        model_reset();
        do_reset();

        // Vector table: clean lock from 8'h01, gap, single error, clear
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].d);
            check($sformatf("table[%0d]", i), dut_vec(),
                  32'({tbl[i].st, tbl[i].lk, tbl[i].ep, tbl[i].wp, tbl[i].ec}));
        end

        // Long clean run: wrap marker once per period
        wraps_fed = 0; wraps_seen = 0;
        for (int i = 0; i < 600; i++) begin
            d = clean();
            if (d == 8'h01) wraps_fed++;
            step("clean_run", 1, 0, d);
            if (wrap_pulse) wraps_seen++;
        end
        check("wrap_count", 32'(wraps_seen), 32'(wraps_fed));
        check("wrap_count_nonzero", 32'(wraps_fed >= 2), 32'd1);

        // Flip 0x02 -> 0x03 while locked
        e0 = m_err;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (clean() == 8'h02) begin
                step("flip_byte", 1, 0, 8'h03);
                check("flip_err_pulse", 32'(err_pulse), 32'd1);
                done = 1;
            end else begin
                step("flip_seek", 1, 0, clean());
            end
        end
        check("flip_found", 32'(done), 32'd1);
        for (int i = 0; i < 8; i++) step("flip_resume", 1, 0, clean());
        check("flip_errcnt", 32'(err_count), 32'(e0 + 1));
        check("flip_locked", 32'(locked), 32'd1);

        // Three consecutive errors drop lock, then relock after 5 clean samples
        e0 = m_err;
        step("burst1", 1, 0, corrupt(clean()));
        step("burst2", 1, 0, corrupt(clean()));
        check("burst_locked_mid", 32'(locked), 32'd1);
        step("burst3", 1, 0, corrupt(clean()));
        check("burst_unlocked", 32'(locked), 32'd0);
        check("burst_errcnt", 32'(err_count), 32'(e0 + 3));
        cnt = 0;
        for (int i = 0; i < 20 && !locked; i++) begin
            step("relock", 1, 0, clean());
            cnt++;
        end
        check("relock_samples", 32'(cnt), 32'(1 + LOCK));

        // Zeros, then random non-sequence bytes: never locks, no errors
        do_reset();
        lk_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step("zeros", 1, 0, 8'h00);
            if (locked) lk_seen++;
        end
        check("zeros_hunt", 32'(state_o), 32'd0);
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom_range(1, 255));
            if (m_state == 1 && d == clean()) d = (d == 8'hFF) ? 8'h01 : d + 8'd1;
            step("junk", 1, 0, d);
            if (locked || state_o == 2'd2) lk_seen++;
        end
        check("junk_never_locked", 32'(lk_seen), 32'd0);
        check("junk_errcnt", 32'(err_count), 32'd0);

        // Gaps between clean samples: lock counts valid samples only
        do_reset();
        cnt = 0;
        for (int i = 0; i < 60 && !locked; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step("gap", 0, 0, 8'($urandom));
            end else begin
                step("gap_clean", 1, 0, clean());
                cnt++;
            end
        end
        check("gap_lock_samples", 32'(cnt), 32'(1 + LOCK));
        check("gap_errcnt", 32'(err_count), 32'd0);
        step("pre_clr_err", 1, 0, corrupt(clean()));
        check("pre_clr_errcnt", 32'(err_count), 32'd1);
        step("clr_with_err", 1, 1, corrupt(clean()));
        check("clr_wins", 32'(err_count), 32'd0);
        for (int i = 0; i < 4; i++) step("post_clr", 1, 0, clean());

        // Async reset mid-LOCKED
        check("pre_rst_locked", 32'(locked), 32'd1);
        @(posedge clk);
        #2 rst = 1;
        #1 check("async_rst_outputs", dut_vec(), 32'd0);
        @(negedge clk);
        valid_in = 0; clr = 0;
        @(posedge clk); #1;
        check("rst_held_outputs", dut_vec(), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 20 && !locked; i++) begin
            step("rst_relock", 1, 0, clean());
            cnt++;
        end
        check("rst_relock_samples", 32'(cnt), 32'(1 + LOCK));

        // Randomized mixed traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 65)      d = (m_state == 0) ? tab[$urandom_range(0, 254)] : clean();
            else if (r < 90) d = 8'($urandom);
            else             d = 8'h00;
            step("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
